fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end on the other side of the pc handshake. It consumes the pc block's addr and returns fetch_unit_valid, the per-cycle "instruction captured, advance" signal.
- Issues word reads to instruction memory over a req/ack interface and buffers returned instructions with their addresses.
- Presents instructions to decode with a valid/ready handshake.
- Discards in-flight and buffered work on a redirect (jump or fault).

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 2, instruction buffer entries; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- pc_addr  in  XLEN  current pc addr; held stable by pc until fetch_unit_valid.
- flush  in  1  redirect: pc_addr changed by jump or fault; discard outstanding work.
- fetch_unit_valid  out  1  instruction for pc_addr captured this cycle; pc advances at this edge.
- mem_req  out  1  read request, held high until mem_ack.
- mem_addr  out  XLEN  word-aligned read address, stable while mem_req is high.
- mem_ack  in  1  one-cycle response strobe; mem_rdata valid with it.
- mem_rdata  in  XLEN  instruction word.
- inst_valid  out  1  buffer head valid.
- inst  out  XLEN  head instruction.
- inst_addr  out  XLEN  head instruction address.
- inst_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset values: state IDLE, mem_req 0, mem_addr 0, buffer count 0. Consequently fetch_unit_valid 0 and inst_valid 0.
- At most one memory request outstanding.
- State IDLE:
  - Issue when !flush, pc_addr[1:0]==0, and (count - pop) < DEPTH.
  - Issue means: next edge mem_req<=1, mem_addr<=pc_addr, state<=WAIT.
  - If pc_addr[1:0]!=0, no request is issued; pc raises its own fault and redirects.
- State WAIT:
  - mem_ack && !flush: push {pc_addr, mem_rdata}, assert fetch_unit_valid combinationally this cycle, mem_req<=0, state<=IDLE.
  - mem_ack && flush: discard data, fetch_unit_valid 0, mem_req<=0, state<=IDLE.
  - flush && !mem_ack: state<=DRAIN, mem_req stays high.
- State DRAIN:
  - Hold mem_req high until mem_ack. On mem_ack, discard data, mem_req<=0, state<=IDLE.
  - flush in DRAIN has no additional effect.
  - fetch_unit_valid is never asserted in DRAIN.
- mem_ack in IDLE is ignored (covers a stale ack after reset).
- Minimum fetch latency: issue edge, then ack no earlier than the cycle after mem_req rises. Peak throughput is one instruction per 2 cycles.
- Buffer:
  - FIFO of DEPTH entries. Push on accepted ack; pop on inst_valid && inst_ready. Simultaneous push and pop leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Push is guaranteed to have space because the issue condition reserves it.
- inst_valid = (count!=0) && !flush. inst and inst_addr come from the head entry and are don't-care when inst_valid=0.
- flush clears count and pointers at the edge; any pop in the flush cycle is ignored. Issue resumes from IDLE the cycle after flush deasserts, using the new pc_addr.
- rst mid-operation: all state returns to reset values at the edge and mem_req drops. Memory must tolerate an abandoned request.

Decomposition:
- Shared package holds:
  - XLEN.
  - fetch state enum {IDLE, WAIT, DRAIN}.
  - fetch_entry struct {addr, inst}.
- Sub-module fetch_buffer: parameterised DEPTH FIFO of fetch_entry with push, pop, clear, count, and head outputs. It is reused by decode-side queues.

Test Plan:
- Basic fetch:
  - Stimulus: rst, then pc_addr=0, mem acks 1 cycle after mem_req with rdata 0x00000013.
  - Required: mem_req=1 and mem_addr=0 at cycle 1; fetch_unit_valid=1 only in the ack cycle; next cycle inst_valid=1, inst=0x13, inst_addr=0.
- Backpressure (DEPTH=2):
  - Stimulus: inst_ready=0, pc_addr 0 then 4.
  - Required: after two pushes, mem_req stays 0 and fetch_unit_valid stays 0. Raising inst_ready for 1 cycle pops inst_addr 0 and the next request issues with mem_addr=8.
- Flush during WAIT:
  - Stimulus: flush pulse while mem_req=1, ack arrives 3 cycles later with 0xDEADBEEF, pc_addr=20.
  - Required: no push, fetch_unit_valid never high, next mem_addr=20, inst_valid=0 until that ack.
- Flush coincident with ack:
  - Required: data dropped, buffer empty, fetch_unit_valid=0 that cycle.
- Unaligned address:
  - Stimulus: pc_addr=1 for 5 cycles.
  - Required: mem_req stays 0, fetch_unit_valid stays 0. pc_addr=0 with flush then resumes fetching at 0.
- Reset mid-WAIT:
  - Stimulus: rst while mem_req=1, stale mem_ack 2 cycles later.
  - Required: mem_req=0 after the rst edge, ack ignored, inst_valid=0, and fetch restarts from the current pc_addr.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end and its buffers.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buffer.sv
// Small FIFO of fetch entries (address + instruction word).
// Also used by decode-side queues, so it knows nothing about the fetch FSM.
// clear wins over push and pop in the same cycle.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output fetch_entry_t                 head
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the queue at the edge.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: reads one word per pc address from instruction
// memory, buffers it with its address and hands it to decode.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no request outstanding; issue when aligned, not flushing, space
//   WAIT  | request outstanding for the current pc; ack is captured
//   DRAIN | request outstanding but made stale by a redirect; ack discarded
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            flush,
    output logic            fetch_unit_valid,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_addr,
    input  logic            inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic            mem_req_d;
    logic [XLEN-1:0] mem_addr_d;

    logic             push;
    logic             pop;
    logic             buf_empty;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] occupancy;
    logic             issue_ok;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Flush hides the head so decode never consumes an entry about to vanish.
    assign inst_valid = !buf_empty && !flush;
    assign pop        = inst_valid && inst_ready;
    assign inst       = head.inst;
    assign inst_addr  = head.addr;

    // Space is reserved at issue time, counting a pop happening this cycle,
    // so the later push never finds the buffer full.
    assign occupancy  = buf_count - CNT_W'(pop);
    assign issue_ok   = !flush && (pc_addr[1:0] == 2'b00) && (occupancy < CNT_W'(DEPTH));

    // pc holds pc_addr until fetch_unit_valid, so it still names the reply.
    assign push_entry.addr = pc_addr;
    assign push_entry.inst = mem_rdata;

    // Next-state, request and capture decisions.
    always_comb begin
        state_d          = state_q;
        mem_req_d        = mem_req;
        mem_addr_d       = mem_addr;
        fetch_unit_valid = 1'b0;
        push             = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_addr;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!flush) begin
                        push             = 1'b1;
                        fetch_unit_valid = 1'b1;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and memory-request registers; reset abandons any outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            mem_req  <= mem_req_d;
            mem_addr <= mem_addr_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (flush),
        .count     (buf_count),
        .empty     (buf_empty),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences followed by a random phase.
// Accepted fetches are queued as expected entries and compared when decode
// consumes them; inst_valid and fetch_unit_valid are checked every cycle.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_addr;
    logic            flush;
    logic            fetch_unit_valid;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            inst_valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_addr;
    logic            inst_ready;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t sb_q[$];
    logic         exp_fv;

    always #5 clk = ~clk;

    fetch_unit #(
        .DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_addr          (pc_addr),
        .flush            (flush),
        .fetch_unit_valid (fetch_unit_valid),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .inst_valid       (inst_valid),
        .inst             (inst),
        .inst_addr        (inst_addr),
        .inst_ready       (inst_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample at negedge, update the scoreboard, return just
    // after the next rising edge so the caller can drive the following cycle.
    task automatic tick();
        fetch_entry_t e;
        @(negedge clk);
        chk("inst_valid", 32'(inst_valid), 32'((sb_q.size() != 0) && !flush));
        chk("fetch_unit_valid", 32'(fetch_unit_valid), 32'(exp_fv));
        if (inst_valid && inst_ready && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_inst", inst, e.inst);
            chk("sb_inst_addr", inst_addr, e.addr);
        end
        if (rst || flush) begin
            sb_q.delete();
        end else if (exp_fv) begin
            e.addr = pc_addr;
            e.inst = mem_rdata;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic do_ack;
        int   nfetch;
        nfetch     = 0;
        rst        = 1'b1;
        pc_addr    = '0;
        flush      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        inst_ready = 1'b0;
        exp_fv     = 1'b0;
        @(posedge clk);
        #1;
        tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);

        // basic fetch at 0, ack one cycle after mem_req rises
        rst = 1'b0;
        tick();
        chk("basic_req", 32'(mem_req), 1);
        chk("basic_addr", mem_addr, 32'h0);
        tick();
        chk("basic_req_held", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013; exp_fv = 1'b1;
        tick();
        mem_ack = 1'b0; exp_fv = 1'b0; pc_addr = 32'h4;
        chk("basic_req_drop", 32'(mem_req), 0);
        chk("basic_inst", inst, 32'h0000_0013);
        chk("basic_inst_addr", inst_addr, 32'h0);
        tick();

        // backpressure: second fetch fills the buffer, then issue stalls
        chk("bp_req4", 32'(mem_req), 1);
        chk("bp_addr4", mem_addr, 32'h4);
        mem_ack = 1'b1; mem_rdata = 32'h0040_0093; exp_fv = 1'b1;
        tick();
        mem_ack = 1'b0; exp_fv = 1'b0; pc_addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            chk("bp_no_req", 32'(mem_req), 0);
            tick();
        end
        inst_ready = 1'b1;
        chk("bp_no_req_pop", 32'(mem_req), 0);
        tick();
        inst_ready = 1'b0;
        chk("bp_resume_req", 32'(mem_req), 1);
        chk("bp_resume_addr", mem_addr, 32'h8);
        mem_ack = 1'b1; mem_rdata = 32'h0080_0113; exp_fv = 1'b1;
        tick();
        mem_ack = 1'b0; exp_fv = 1'b0; pc_addr = 32'hC; inst_ready = 1'b1;
        tick();

        // flush while waiting; stale ack three cycles later
        chk("fw_req", 32'(mem_req), 1);
        chk("fw_addr", mem_addr, 32'hC);
        flush = 1'b1; pc_addr = 32'd20;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("fw_drain_req", 32'(mem_req), 1);
            chk("fw_drain_addr", mem_addr, 32'hC);
            tick();
        end
        chk("fw_drain_req_ack", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("fw_idle_req", 32'(mem_req), 0);
        tick();
        chk("fw_new_req", 32'(mem_req), 1);
        chk("fw_new_addr", mem_addr, 32'd20);
        mem_ack = 1'b1; mem_rdata = 32'h0140_0193; exp_fv = 1'b1;
        tick();
        mem_ack = 1'b0; exp_fv = 1'b0; pc_addr = 32'd24;
        tick();

        // flush coincident with ack
        inst_ready = 1'b0;
        chk("fa_req", 32'(mem_req), 1);
        chk("fa_addr", mem_addr, 32'd24);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111; flush = 1'b1; pc_addr = 32'd40;
        tick();
        mem_ack = 1'b0; flush = 1'b0;
        chk("fa_req_drop", 32'(mem_req), 0);
        tick();
        chk("fa_new_req", 32'(mem_req), 1);
        chk("fa_new_addr", mem_addr, 32'd40);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222; exp_fv = 1'b1;
        tick();

        // unaligned pc: no request until redirect to an aligned address
        mem_ack = 1'b0; exp_fv = 1'b0; pc_addr = 32'h1; inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ua_no_req", 32'(mem_req), 0);
            tick();
        end
        pc_addr = 32'h0; flush = 1'b1;
        chk("ua_flush_no_req", 32'(mem_req), 0);
        tick();
        flush = 1'b0;
        chk("ua_post_flush_no_req", 32'(mem_req), 0);
        tick();
        chk("ua_resume_req", 32'(mem_req), 1);
        chk("ua_resume_addr", mem_addr, 32'h0);

        // reset while waiting, stale ack two cycles after reset asserts
        rst = 1'b1;
        tick();
        chk("rw_req_drop", 32'(mem_req), 0);
        tick();
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
        chk("rw_stale_no_req", 32'(mem_req), 0);
        tick();
        chk("rw_restart_req", 32'(mem_req), 1);
        chk("rw_restart_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0513; exp_fv = 1'b1;
        tick();
        mem_ack = 1'b0; exp_fv = 1'b0; pc_addr = 32'h4;
        tick();

        // random ack latency and decode backpressure
        for (int i = 0; i < 300; i++) begin
            if (mem_req) begin
                chk("rand_addr", mem_addr, pc_addr);
            end
            do_ack     = mem_req && ($urandom_range(0, 2) != 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            mem_ack    = do_ack;
            mem_rdata  = $urandom();
            exp_fv     = do_ack;
            tick();
            if (do_ack) begin
                pc_addr = pc_addr + 32'd4;
                nfetch++;
            end
        end
        mem_ack = 1'b0; exp_fv = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
            tick();
        end
        if (sb_q.size() != 0) begin
            chk("drain_timeout", 32'(sb_q.size()), 0);
        end
        chk("rand_progress", 32'(nfetch > 20), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
